mcu_block_sequencer: RTL and testbench

- Sequences the 12-bit zig-zag coefficient stream leaving the zig-zag ping-pong buffer into JPEG MCU structure for the entropy coder.
- Each MCU is 8 blocks of 64 coefficients in 4:2:2 order: 4 Y, 2 Cb, 2 Cr.
- Tags every coefficient with component, block index and DC/last flags, and converts each block's DC term into a per-component DC difference.
- Detects MCU and frame boundaries, and flags stray coefficients.

---
 rtl/mcu_block_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_mcu_block_sequencer.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/mcu_block_sequencer.sv
// mcu_block_sequencer: arranges the zig-zag coefficient stream into 4:2:2 JPEG MCUs,
// tagging each beat and turning block DC terms into per-component DC differences.
`default_nettype none

module mcu_block_sequencer #(
  parameter int MCU_NUM = 2400,
  parameter int Y_BLK   = 4,
  parameter int C_BLK   = 2
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        frame_start,
  input  logic [11:0] coef_in,
  input  logic        coef_valid,
  output logic [12:0] coef_out,
  output logic        coef_out_valid,
  output logic [1:0]  comp_id,
  output logic [2:0]  blk_idx,
  output logic        first_coef,
  output logic        last_coef,
  output logic        mcu_done,
  output logic        frame_done,
  output logic [11:0] mcu_cnt,
  output logic        err_stray
);

  localparam logic [1:0]  S_IDLE   = 2'd0;
  localparam logic [1:0]  S_RUN    = 2'd1;
  localparam logic [1:0]  S_DONE   = 2'd2;
  localparam logic [2:0]  CB_START = 3'(Y_BLK);
  localparam logic [2:0]  CR_START = 3'(Y_BLK + C_BLK);
  localparam logic [11:0] LAST_MCU = 12'(MCU_NUM - 1);

  logic [1:0]  state_q, state_d;
  logic [5:0]  idx_q, idx_d;
  logic [2:0]  blk_q, blk_d;
  logic [11:0] mcu_q, mcu_d;
  logic [11:0] pred_y_q, pred_y_d, pred_cb_q, pred_cb_d, pred_cr_q, pred_cr_d;
  logic        err_q, err_d;
  logic [12:0] out_q, out_d;
  logic        vld_q, vld_d, first_q, first_d, last_q, last_d;
  logic        mdone_q, mdone_d, fdone_q, fdone_d;
  logic [1:0]  comp_q, comp_d;
  logic [2:0]  oblk_q, oblk_d;
  logic [11:0] omcu_q, omcu_d;

  // frame_start restarts counting in the same cycle, so the effective position is zero
  logic        accept;
  logic [5:0]  cur_idx;
  logic [2:0]  cur_blk;
  logic [11:0] cur_mcu;
  logic [1:0]  cur_comp;
  logic [11:0] cur_pred;
  logic        is_last, is_mcu_end, is_frame_end;
  logic [12:0] dc_diff;

  assign accept       = coef_valid && ((state_q == S_RUN) || frame_start);
  assign cur_idx      = frame_start ? 6'd0  : idx_q;
  assign cur_blk      = frame_start ? 3'd0  : blk_q;
  assign cur_mcu      = frame_start ? 12'd0 : mcu_q;
  assign cur_comp     = (cur_blk < CB_START) ? 2'd1 : (cur_blk < CR_START) ? 2'd2 : 2'd3;
  assign cur_pred     = frame_start ? 12'd0 :
                        (cur_comp == 2'd1) ? pred_y_q :
                        (cur_comp == 2'd2) ? pred_cb_q : pred_cr_q;
  assign is_last      = (cur_idx == 6'd63);
  assign is_mcu_end   = is_last && (cur_blk == 3'd7);
  assign is_frame_end = is_mcu_end && (cur_mcu == LAST_MCU);
  assign dc_diff      = {coef_in[11], coef_in} - {cur_pred[11], cur_pred};

  always_ff @(negedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      blk_q     <= '0;
      mcu_q     <= '0;
      pred_y_q  <= '0;
      pred_cb_q <= '0;
      pred_cr_q <= '0;
      err_q     <= 1'b0;
      out_q     <= '0;
      vld_q     <= 1'b0;
      first_q   <= 1'b0;
      last_q    <= 1'b0;
      mdone_q   <= 1'b0;
      fdone_q   <= 1'b0;
      comp_q    <= '0;
      oblk_q    <= '0;
      omcu_q    <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      blk_q     <= blk_d;
      mcu_q     <= mcu_d;
      pred_y_q  <= pred_y_d;
      pred_cb_q <= pred_cb_d;
      pred_cr_q <= pred_cr_d;
      err_q     <= err_d;
      out_q     <= out_d;
      vld_q     <= vld_d;
      first_q   <= first_d;
      last_q    <= last_d;
      mdone_q   <= mdone_d;
      fdone_q   <= fdone_d;
      comp_q    <= comp_d;
      oblk_q    <= oblk_d;
      omcu_q    <= omcu_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (frame_start) state_d = S_RUN;
      S_RUN:   if (accept && is_frame_end && !frame_start) state_d = S_DONE;
      S_DONE:  state_d = frame_start ? S_RUN : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    idx_d     = idx_q;
    blk_d     = blk_q;
    mcu_d     = mcu_q;
    pred_y_d  = pred_y_q;
    pred_cb_d = pred_cb_q;
    pred_cr_d = pred_cr_q;
    err_d     = err_q;
    out_d     = out_q;
    oblk_d    = oblk_q;
    omcu_d    = omcu_q;
    vld_d     = 1'b0;
    first_d   = 1'b0;
    last_d    = 1'b0;
    mdone_d   = 1'b0;
    fdone_d   = 1'b0;
    comp_d    = 2'd0;

    if (frame_start) begin
      idx_d     = '0;
      blk_d     = '0;
      mcu_d     = '0;
      pred_y_d  = '0;
      pred_cb_d = '0;
      pred_cr_d = '0;
      err_d     = 1'b0;
    end else if (coef_valid && (state_q != S_RUN)) begin
      err_d = 1'b1;
    end

    if (accept) begin
      vld_d   = 1'b1;
      comp_d  = cur_comp;
      oblk_d  = cur_blk;
      omcu_d  = cur_mcu;
      first_d = (cur_idx == 6'd0);
      last_d  = is_last;
      mdone_d = is_mcu_end;
      fdone_d = is_frame_end;
      if (cur_idx == 6'd0) begin
        out_d = dc_diff;
        case (cur_comp)
          2'd1:    pred_y_d  = coef_in;
          2'd2:    pred_cb_d = coef_in;
          default: pred_cr_d = coef_in;
        endcase
      end else begin
        out_d = {coef_in[11], coef_in};
      end
      idx_d = cur_idx + 6'd1;
      blk_d = is_last ? cur_blk + 3'd1 : cur_blk;
      mcu_d = is_mcu_end ? cur_mcu + 12'd1 : cur_mcu;
      if (is_frame_end) begin
        idx_d = '0;
        blk_d = '0;
        mcu_d = '0;
      end
    end
  end

  assign coef_out       = out_q;
  assign coef_out_valid = vld_q;
  assign comp_id        = comp_q;
  assign blk_idx        = oblk_q;
  assign first_coef     = first_q;
  assign last_coef      = last_q;
  assign mcu_done       = mdone_q;
  assign frame_done     = fdone_q;
  assign mcu_cnt        = omcu_q;
  assign err_stray      = err_q;

endmodule

`default_nettype wire

// File: tb/tb_mcu_block_sequencer.sv
// tb_mcu_block_sequencer: directed-vector bench for mcu_block_sequencer with MCU_NUM=2.
`default_nettype none

module tb_mcu_block_sequencer;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        frame_start = 1'b0;
  logic [11:0] coef_in = '0;
  logic        coef_valid = 1'b0;
  logic [12:0] coef_out;
  logic        coef_out_valid;
  logic [1:0]  comp_id;
  logic [2:0]  blk_idx;
  logic        first_coef, last_coef, mcu_done, frame_done, err_stray;
  logic [11:0] mcu_cnt;

  int n_checks = 0;
  int n_errors = 0;

  mcu_block_sequencer #(.MCU_NUM(2), .Y_BLK(4), .C_BLK(2)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .frame_start(frame_start),
    .coef_in(coef_in), .coef_valid(coef_valid), .coef_out(coef_out),
    .coef_out_valid(coef_out_valid), .comp_id(comp_id), .blk_idx(blk_idx),
    .first_coef(first_coef), .last_coef(last_coef), .mcu_done(mcu_done),
    .frame_done(frame_done), .mcu_cnt(mcu_cnt), .err_stray(err_stray)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Inputs change at a rising edge; the DUT samples them at the following falling edge.
  task automatic cyc(input logic v, input logic [11:0] d, input logic fs);
    coef_valid  = v;
    coef_in     = d;
    frame_start = fs;
    @(posedge sys_clk);
  endtask

  int dc_tab  [16] = '{100, 110, 90, 90, 5, -3, -7, -7, -2048, 2047, 2047, -2048, 0, 0, 0, 0};
  int exp_tab [16] = '{100, 10, -20, 0, 5, -8, -7, 0, -2138, 4095, 0, -4095, 3, 0, 7, 0};

  initial begin
    logic [12:0] e13;
    logic [11:0] d12;
    int blk, idx, m, ecomp;

    @(posedge sys_clk);
    @(posedge sys_clk);
    chk("rst_valid", coef_out_valid, 0);
    chk("rst_coef", coef_out, 0);
    chk("rst_mcu", mcu_cnt, 0);
    chk("rst_err", err_stray, 0);
    sys_rst_n = 1'b1;

    // Two full MCUs, contiguous
    cyc(0, 0, 1);
    chk("arm_novalid", coef_out_valid, 0);
    for (int b = 0; b < 1024; b++) begin
      idx = b % 64;
      blk = (b / 64) % 8;
      m   = b / 512;
      d12 = (idx == 0) ? 12'(dc_tab[m*8+blk]) : (idx == 1) ? 12'hFFF : 12'(idx);
      cyc(1, d12, 0);
      ecomp = (blk < 4) ? 1 : (blk < 6) ? 2 : 3;
      chk("comp_id", comp_id, ecomp);
      chk("blk_idx", blk_idx, blk);
      chk("mcu_cnt", mcu_cnt, m);
      chk("mcu_done", mcu_done, (b == 511 || b == 1023) ? 1 : 0);
      chk("frame_done", frame_done, (b == 1023) ? 1 : 0);
      chk("last_coef", last_coef, (idx == 63) ? 1 : 0);
      if (idx == 0) begin
        e13 = 13'(exp_tab[m*8+blk]);
        chk("dc_first", first_coef, 1);
        chk("dc_diff", coef_out, e13);
      end else if (idx == 1) begin
        chk("ac_neg", coef_out, 13'h1FFF);
      end else if (idx == 2 || idx == 63) begin
        chk("ac_pos", coef_out, idx);
      end
    end

    // DONE then IDLE; a beat in IDLE is stray
    cyc(0, 0, 0);
    chk("done_novalid", coef_out_valid, 0);
    cyc(1, 12'd5, 0);
    chk("stray_novalid", coef_out_valid, 0);
    chk("stray_err", err_stray, 1);
    chk("stray_hold", coef_out, 63);
    chk("stray_comp", comp_id, 0);
    cyc(0, 0, 1);
    chk("fs_clr_err", err_stray, 0);

    // Gapped valid 1,0,1,0
    cyc(1, 12'd50, 0);
    chk("gap_v0", coef_out_valid, 1);
    chk("gap_dc", coef_out, 50);
    chk("gap_first0", first_coef, 1);
    cyc(0, 12'd99, 0);
    chk("gap_v1", coef_out_valid, 0);
    chk("gap_hold", coef_out, 50);
    chk("gap_first1", first_coef, 0);
    chk("gap_comp", comp_id, 0);
    cyc(1, 12'd7, 0);
    chk("gap_v2", coef_out_valid, 1);
    chk("gap_ac", coef_out, 7);
    chk("gap_first2", first_coef, 0);
    chk("gap_blk", blk_idx, 0);
    cyc(0, 0, 0);
    chk("gap_v3", coef_out_valid, 0);

    // Mid-frame abort at beat 300
    cyc(0, 0, 1);
    for (int b = 0; b < 300; b++) cyc(1, (b % 64 == 0) ? 12'd200 : 12'd1, 0);
    cyc(1, 12'd33, 1);
    chk("abort_first", first_coef, 1);
    chk("abort_dc", coef_out, 33);
    chk("abort_blk", blk_idx, 0);
    chk("abort_mcu", mcu_cnt, 0);
    chk("abort_mdone", mcu_done, 0);
    for (int nb = 1; nb < 512; nb++) begin
      cyc(1, (nb % 64 == 0) ? 12'd33 : 12'd1, 0);
      chk("abort_mcu_done", mcu_done, (nb == 511) ? 1 : 0);
      if (nb == 64) chk("abort_dc2", coef_out, 0);
    end
    chk("abort_blk7", blk_idx, 7);
    for (int nb = 0; nb < 3; nb++) cyc(1, 12'd2, 0);
    chk("pre_rst_mcu", mcu_cnt, 1);

    // Asynchronous reset mid-frame
    #2 sys_rst_n = 1'b0;
    #1;
    chk("arst_mcu", mcu_cnt, 0);
    chk("arst_coef", coef_out, 0);
    chk("arst_valid", coef_out_valid, 0);
    chk("arst_blk", blk_idx, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
